reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Register file at the receiving end of the write-back path.
- Consumes the destination index (WriteReg, chosen by RegDst) and the write-back data (WriteData_Reg, chosen by MemtoReg).
- Commits writes on the clock edge and supplies the two combinational read operands (ReadData1, ReadData2) to the ALU-operand path.
- Also keeps a saturating count of committed writes for bring-up and debug.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, index width; number of registers NUM_REGS = 2**ADDR_W.
- CNT_W, 16, width of the committed-write counter.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- RegWrite  input  1  write enable for the current cycle.
- WriteReg  input  ADDR_W  destination register index.
- WriteData_Reg  input  DATA_W  write-back data.
- ReadReg1  input  ADDR_W  source index for port 1.
- ReadReg2  input  ADDR_W  source index for port 2.
- ReadData1  output  DATA_W  read data, port 1.
- ReadData2  output  DATA_W  read data, port 2.
- WriteCount  output  CNT_W  number of committed writes, saturating.
- WriteCountSat  output  1  high once WriteCount reaches its maximum.

Behaviour:
- Clock and reset (already decided): one clock, Clk; reset is asynchronous and active-low, Reset_n.
- Reset:
  - Reset_n low clears all NUM_REGS registers to 0, WriteCount to 0 and WriteCountSat to 0, immediately and independent of Clk.
  - Reset held across a rising edge blocks any write on that edge.
  - Reset deasserted mid-program: the first write is taken on the first rising edge with Reset_n high.
- Write:
  - On the rising edge, if RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData_Reg.
  - Write latency: 1 cycle. New data is visible to reads in the cycle after the edge, unless bypass is enabled.
- Register 0:
  - Hardwired to zero. A write to index 0 is discarded; the storage element stays 0.
  - Reads of index 0 always return 0 on both ports.
- Read:
  - Purely combinational from the indices and the array; no read enable.
  - Both ports are independent; ReadReg1==ReadReg2 returns identical data on both.
- WriteCount:
  - Increments by 1 on each rising edge where a write commits (RegWrite=1 and WriteReg!=0).
  - Writes to register 0 and cycles with RegWrite=0 do not count.
  - Saturates at 2**CNT_W-1; no wrap.
  - WriteCountSat is registered and goes high on the same edge WriteCount reaches its maximum.
- X-handling: RegWrite=X is treated as no write. The verification bench flags it as an assertion failure.
- Indices: WriteReg and ReadReg are full-width, so no out-of-range index is possible.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read-during-write forwarding is added.
  - If RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle, ReadDataN = WriteData_Reg combinationally, before the edge.
  - Applies to both ports independently. Index 0 still reads 0.
- Undefined:
  - ReadDataN returns the pre-write array contents in the write cycle.
  - The new value appears only after the rising edge.
- Array, reset and counter behaviour are identical in both builds.

Test Plan:
- Reset: hold Reset_n=0 mid-cycle after writing reg[5]=0xDEADBEEF -> ReadData1 for ReadReg1=5 reads 0x00000000 immediately; WriteCount=0.
- Basic write/read: RegWrite=1, WriteReg=7, WriteData_Reg=0x12345678, one edge; then ReadReg1=7, ReadReg2=7 -> both ports 0x12345678; WriteCount=1.
- Register 0: RegWrite=1, WriteReg=0, WriteData_Reg=0xFFFFFFFF, one edge -> ReadData1 for index 0 = 0; WriteCount unchanged.
- Same-cycle read of written index: write reg[3]=0xA5A5A5A5 while ReadReg2=3 holds old value 0x11111111 -> with REGFILE_BYPASS_EN ReadData2=0xA5A5A5A5 before the edge; without it ReadData2=0x11111111 before and 0xA5A5A5A5 after the edge.
- Counter saturation: build with CNT_W=4, perform 20 writes to reg 1 -> WriteCount=15, WriteCountSat=1 from the 15th write on.
- RegWrite=0 hold: present WriteReg=9, WriteData_Reg=0xCAFEF00D with RegWrite=0 for 3 edges -> reg[9] unchanged (0); WriteCount unchanged.

Source files
------------

// File: rtl/reg_file_wb.sv
// reg_file_wb: register file at the receiving end of the write-back path.
// Two independent combinational read ports, one clocked write port, register 0
// hardwired to zero, and a saturating count of committed writes for bring-up.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read port whose index matches the write index (before the clock edge).
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData_Reg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [CNT_W-1:0]  WriteCount,
  output logic              WriteCountSat
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write commits only when enabled and not aimed at the zero register.
  // An unknown RegWrite falls through the if below as "no write".
  logic commit;
  assign commit = RegWrite && (WriteReg != '0);

  // Array storage: cleared asynchronously, written on the rising edge.
  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      regs <= '{default: '0};
    end else if (commit) begin
      regs[WriteReg] <= WriteData_Reg;
    end
  end

  // Committed-write counter: stops at all-ones, flag rises on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteCount    <= '0;
      WriteCountSat <= 1'b0;
    end else if (commit && (WriteCount != CNT_MAX)) begin
      WriteCount    <= WriteCount + CNT_W'(1);
      WriteCountSat <= (WriteCount == CNT_MAX - CNT_W'(1));
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read ports with forwarding of the in-flight write; index 0 always reads 0.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadData2 = regs[ReadReg2];
    if (commit && (ReadReg1 == WriteReg)) ReadData1 = WriteData_Reg;
    if (commit && (ReadReg2 == WriteReg)) ReadData2 = WriteData_Reg;
    if (ReadReg1 == '0) ReadData1 = '0;
    if (ReadReg2 == '0) ReadData2 = '0;
  end
`else
  // Read ports return the array contents; a same-cycle write shows up after the edge.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadData2 = regs[ReadReg2];
    if (ReadReg1 == '0) ReadData1 = '0;
    if (ReadReg2 == '0) ReadData2 = '0;
  end
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed plus short random stimulus for reg_file_wb.
// Expected values are pushed into exp_q as stimulus is driven and popped when
// the matching DUT output is sampled. A second instance with CNT_W=4 covers
// counter saturation. Build with REGFILE_BYPASS_EN to exercise forwarding.
module tb_reg_file_wb;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (CNT_W = 16) ----------------
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [15:0] write_count;
  logic        write_count_sat;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .Clk           (clk),
    .Reset_n       (reset_n),
    .RegWrite      (reg_write),
    .WriteReg      (write_reg),
    .WriteData_Reg (write_data),
    .ReadReg1      (read_reg1),
    .ReadReg2      (read_reg2),
    .ReadData1     (read_data1),
    .ReadData2     (read_data2),
    .WriteCount    (write_count),
    .WriteCountSat (write_count_sat)
  );

  // ---------------- saturation DUT (CNT_W = 4) ----------------
  logic        s_reg_write;
  logic [4:0]  s_write_reg;
  logic [31:0] s_write_data;
  logic [4:0]  s_read_reg1;
  logic [4:0]  s_read_reg2;
  logic [31:0] s_read_data1;
  logic [31:0] s_read_data2;
  logic [3:0]  s_count;
  logic        s_sat;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
    .Clk           (clk),
    .Reset_n       (reset_n),
    .RegWrite      (s_reg_write),
    .WriteReg      (s_write_reg),
    .WriteData_Reg (s_write_data),
    .ReadReg1      (s_read_reg1),
    .ReadReg2      (s_read_reg2),
    .ReadData1     (s_read_data1),
    .ReadData2     (s_read_data2),
    .WriteCount    (s_count),
    .WriteCountSat (s_sat)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  int exp_count = 0;

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // RegWrite must never be unknown while out of reset.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      assert (!$isunknown(reg_write) && !$isunknown(s_reg_write)) else begin
        errors++;
        $error("FAIL regwrite_x: observed %b/%b expected known", reg_write, s_reg_write);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [4:0] idx, input logic [31:0] d);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = d;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_count = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  r_idx;
    logic [4:0]  r_rd2;
    logic [31:0] r_dat;
    logic        r_we;

    reset_n      = 1'b0;
    reg_write    = 1'b0;
    write_reg    = '0;
    write_data   = '0;
    read_reg1    = 5'd5;
    read_reg2    = 5'd0;
    s_reg_write  = 1'b0;
    s_write_reg  = 5'd1;
    s_write_data = '0;
    s_read_reg1  = 5'd1;
    s_read_reg2  = 5'd0;
    model_reset();

    // Reset state
    #12;
    exp_q.push_back(64'h0); check("reset_rd1", read_data1);
    exp_q.push_back(64'h0); check("reset_count", write_count);
    exp_q.push_back(64'h0); check("reset_sat", write_count_sat);
    @(negedge clk);
    reset_n = 1'b1;

    // Write reg5, then assert reset mid-cycle and see it clear immediately
    drive_write(5'd5, 32'hDEADBEEF);
    drive_idle();
    read_reg1 = 5'd5;
    #1;
    exp_q.push_back(64'hDEADBEEF); check("pre_reset_rd1", read_data1);
    exp_q.push_back(64'd1);        check("pre_reset_count", write_count);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(64'h0); check("async_reset_rd1", read_data1);
    exp_q.push_back(64'h0); check("async_reset_count", write_count);
    model_reset();

    // Write held across an edge during reset is blocked
    reg_write  = 1'b1;
    write_reg  = 5'd6;
    write_data = 32'h600DCAFE;
    read_reg2  = 5'd6;
    @(negedge clk);
    #1;
    exp_q.push_back(64'h0); check("reset_blocks_write", read_data2);
    reset_n = 1'b1;
    // First rising edge with reset high takes the write
    drive_idle();
    #1;
    exp_q.push_back(64'h600DCAFE); check("first_write_after_reset", read_data2);
    exp_q.push_back(64'd1);        check("first_write_count", write_count);
    model[6] = 32'h600DCAFE; exp_count = 1;

    // Basic write/read, both ports on the same index
    drive_write(5'd7, 32'h12345678);
    drive_idle();
    read_reg1 = 5'd7; read_reg2 = 5'd7;
    #1;
    exp_q.push_back(64'h12345678); check("basic_rd1", read_data1);
    exp_q.push_back(64'h12345678); check("basic_rd2", read_data2);
    exp_q.push_back(64'd2);        check("basic_count", write_count);
    model[7] = 32'h12345678; exp_count = 2;

    // Register 0 write is discarded and not counted
    drive_write(5'd0, 32'hFFFFFFFF);
    drive_idle();
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    exp_q.push_back(64'h0); check("r0_rd1", read_data1);
    exp_q.push_back(64'h0); check("r0_rd2", read_data2);
    exp_q.push_back(64'd2); check("r0_count", write_count);

    // Same-cycle read of the index being written
    drive_write(5'd3, 32'h11111111);
    drive_write(5'd3, 32'hA5A5A5A5);
    read_reg1 = 5'd0; read_reg2 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'hA5A5A5A5);
`else
    exp_q.push_back(64'h11111111);
`endif
    check("same_cycle_rd2", read_data2);
    write_reg = 5'd0; read_reg1 = 5'd0;
    #1;
    exp_q.push_back(64'h0); check("same_cycle_r0_rd1", read_data1);
    write_reg = 5'd3;
    drive_idle();
    #1;
    exp_q.push_back(64'hA5A5A5A5); check("after_edge_rd2", read_data2);
    exp_q.push_back(64'd4);        check("after_edge_count", write_count);
    model[3] = 32'hA5A5A5A5; exp_count = 4;

    // RegWrite=0 held for three edges changes nothing
    @(negedge clk);
    reg_write = 1'b0; write_reg = 5'd9; write_data = 32'hCAFEF00D;
    read_reg1 = 5'd9;
    repeat (3) @(negedge clk);
    #1;
    exp_q.push_back(64'h0); check("hold_rd1", read_data1);
    exp_q.push_back(64'd4); check("hold_count", write_count);

    // Short random sequence against a reference array
    for (int n = 0; n < 12; n++) begin
      r_idx = 5'($urandom_range(0, 31));
      r_rd2 = 5'($urandom_range(0, 31));
      r_dat = $urandom;
      r_we  = 1'($urandom_range(0, 1));
      @(negedge clk);
      reg_write = r_we; write_reg = r_idx; write_data = r_dat;
      read_reg1 = r_idx; read_reg2 = r_rd2;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back((r_we && r_idx != 0) ? {32'h0, r_dat} : {32'h0, model[r_idx]});
      exp_q.push_back((r_we && r_idx != 0 && r_rd2 == r_idx) ? {32'h0, r_dat} : {32'h0, model[r_rd2]});
`else
      exp_q.push_back({32'h0, model[r_idx]});
      exp_q.push_back({32'h0, model[r_rd2]});
`endif
      check("rand_rd1", read_data1);
      check("rand_rd2", read_data2);
      if (r_we && r_idx != 0) begin
        model[r_idx] = r_dat;
        exp_count++;
      end
    end
    drive_idle();
    #1;
    exp_q.push_back(64'(exp_count)); check("rand_count", write_count);
    exp_q.push_back(64'h0);          check("rand_sat", write_count_sat);

    // Counter saturation on the CNT_W=4 instance
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      s_reg_write = 1'b1; s_write_data = 32'(k);
      exp_q.push_back(64'((k > 15) ? 15 : k));
      exp_q.push_back(64'(k >= 15));
      @(negedge clk);
      s_reg_write = 1'b0;
      #1;
      check("sat_count", s_count);
      check("sat_flag", s_sat);
    end
    exp_q.push_back(64'd20); check("sat_data", s_read_data1);
    exp_q.push_back(64'h0);  check("sat_r0", s_read_data2);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover_expected: observed %0d queued expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
